bus_arbiter: RTL and testbench

Two-master arbiter for the shared system bus. It sits between the two master ports (m1, m2) driven by the command processor and the bus slave side. It grants exactly one master at a time, latches that master's slave select onto the bus, and holds the grant until the transfer completes, the master withdraws its request, or a hold timeout expires. A one-cycle turnaround separates consecutive grants.

---
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant and slave-select signals between the two
// bus masters, the slave-side completion strobe and the bus arbiter.
//
// Handshake: a master raises req_mX as a level and keeps it high for the
// whole transfer; it owns the bus only while grant_mX is high. The transfer
// ends when the slave side pulses xfer_done for one cycle, when the master
// drops req_mX, or when the arbiter revokes the grant (timeout pulse).
interface bus_arbiter_if #(
    parameter int SLAVE_LEN = 2
);
    logic                      req_m1;
    logic                      req_m2;
    logic [SLAVE_LEN-1:0]      slave_select_m1;
    logic [SLAVE_LEN-1:0]      slave_select_m2;
    logic                      xfer_done;
    logic                      grant_m1;
    logic                      grant_m2;
    logic                      bus_busy;
    logic [SLAVE_LEN-1:0]      slave_select;
    logic [2**SLAVE_LEN-1:0]   slave_en;
    logic                      timeout;

    // Requesting side (masters and slave-side completion strobe)
    modport master (
        output req_m1, req_m2, slave_select_m1, slave_select_m2, xfer_done,
        input  grant_m1, grant_m2, bus_busy, slave_select, slave_en, timeout
    );

    // Arbiter side
    modport slave (
        input  req_m1, req_m2, slave_select_m1, slave_select_m2, xfer_done,
        output grant_m1, grant_m2, bus_busy, slave_select, slave_en, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the shared system bus.
// Grants one master at a time, latches its slave select, and holds the grant
// until xfer_done, request withdrawal or a hold timeout. A RELEASE cycle
// separates any two grants. All outputs are registered.
// Optional build macro BUS_ARB_FIXED_PRIO_EN: ties always go to master 1
// (master 2 may starve); default build uses round-robin tie-break.
module bus_arbiter #(
    parameter int SLAVE_LEN = 2,
    parameter int HOLD_MAX  = 64,
    parameter int CNT_LEN   = 7
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int NSLV = 2**SLAVE_LEN;
    localparam logic [CNT_LEN-1:0] HOLD_LAST = CNT_LEN'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [CNT_LEN-1:0] CNT_ONE   = CNT_LEN'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M1 = 2'd1,
        GRANT_M2 = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_LEN-1:0]   cnt_q, cnt_d;
    logic                 grant_m1_q, grant_m1_d;
    logic                 grant_m2_q, grant_m2_d;
    logic                 bus_busy_q, bus_busy_d;
    logic [SLAVE_LEN-1:0] slave_select_q, slave_select_d;
    logic [NSLV-1:0]      slave_en_q, slave_en_d;
    logic                 timeout_q, timeout_d;

    logic prefer_m1;
    logic win_m1;
    logic win_m2;
    logic own_req;
    logic hold_hit;

    function automatic logic [NSLV-1:0] onehot(input logic [SLAVE_LEN-1:0] sel);
        logic [NSLV-1:0] r;
        r = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign prefer_m1 = 1'b1;
`else
    // last_grant: 1 = master 1 was granted last, 0 = master 2 (reset value)
    logic last_m1_q, last_m1_d;

    assign prefer_m1 = ~last_m1_q;

    // Remember the most recent grant so the other master wins the next tie
    always_comb begin
        last_m1_d = last_m1_q;
        if ((state_q == IDLE) || (state_q == RELEASE)) begin
            if (win_m1)      last_m1_d = 1'b1;
            else if (win_m2) last_m1_d = 1'b0;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk) begin
        if (reset) last_m1_q <= 1'b0;
        else       last_m1_q <= last_m1_d;
    end
`endif

    assign win_m1   = bus.req_m1 & (~bus.req_m2 | prefer_m1);
    assign win_m2   = bus.req_m2 & ~win_m1;
    assign own_req  = (state_q == GRANT_M1) ? bus.req_m1 : bus.req_m2;
    assign hold_hit = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        grant_m1_d     = 1'b0;
        grant_m2_d     = 1'b0;
        slave_select_d = slave_select_q;
        slave_en_d     = '0;
        timeout_d      = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (win_m1) begin
                    state_d        = GRANT_M1;
                    grant_m1_d     = 1'b1;
                    slave_select_d = bus.slave_select_m1;
                    slave_en_d     = onehot(bus.slave_select_m1);
                    cnt_d          = '0;
                end else if (win_m2) begin
                    state_d        = GRANT_M2;
                    grant_m2_d     = 1'b1;
                    slave_select_d = bus.slave_select_m2;
                    slave_en_d     = onehot(bus.slave_select_m2);
                    cnt_d          = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_M1, GRANT_M2: begin
                // Completion beats abandonment beats timeout
                if (bus.xfer_done || !own_req) begin
                    state_d = RELEASE;
                end else if (hold_hit) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                    grant_m1_d = (state_q == GRANT_M1);
                    grant_m2_d = (state_q == GRANT_M2);
                    slave_en_d = slave_en_q;
                end
            end
            default: state_d = IDLE;
        endcase
        bus_busy_d = grant_m1_d | grant_m2_d;
    end

    // State, hold counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            grant_m1_q     <= 1'b0;
            grant_m2_q     <= 1'b0;
            bus_busy_q     <= 1'b0;
            slave_select_q <= '0;
            slave_en_q     <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            grant_m1_q     <= grant_m1_d;
            grant_m2_q     <= grant_m2_d;
            bus_busy_q     <= bus_busy_d;
            slave_select_q <= slave_select_d;
            slave_en_q     <= slave_en_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.grant_m1     = grant_m1_q;
    assign bus.grant_m2     = grant_m2_q;
    assign bus.bus_busy     = bus_busy_q;
    assign bus.slave_select = slave_select_q;
    assign bus.slave_en     = slave_en_q;
    assign bus.timeout      = timeout_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed table-driven bench for bus_arbiter built with
// HOLD_MAX=4. Each table row gives the inputs presented before a rising edge
// and the outputs expected just after that edge. Expected tie-break order
// follows BUS_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_bus_arbiter;
    localparam int SLAVE_LEN = 2;
    localparam int OUT_W     = 10;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    bus_arbiter_if #(.SLAVE_LEN(SLAVE_LEN)) bus ();

    bus_arbiter #(
        .SLAVE_LEN(SLAVE_LEN),
        .HOLD_MAX (4),
        .CNT_LEN  (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       r1;
        logic       r2;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       done;
        logic       g1;
        logic       g2;
        logic       busy;
        logic [1:0] ss;
        logic [3:0] en;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [OUT_W-1:0] exp_q[$];

    task automatic add(input logic rst, input logic r1, input logic r2,
                       input logic [1:0] s1, input logic [1:0] s2, input logic done,
                       input logic g1, input logic g2, input logic busy,
                       input logic [1:0] ss, input logic [3:0] en, input logic to);
        vec_t v;
        v.rst = rst; v.r1 = r1; v.r2 = r2; v.s1 = s1; v.s2 = s2; v.done = done;
        v.g1 = g1; v.g2 = g2; v.busy = busy; v.ss = ss; v.en = en; v.to = to;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic r1, input logic r2,
                         input logic [1:0] s1, input logic [1:0] s2, input logic done);
        reset               = rst;
        bus.req_m1          = r1;
        bus.req_m2          = r2;
        bus.slave_select_m1 = s1;
        bus.slave_select_m2 = s2;
        bus.xfer_done       = done;
    endtask

    function automatic logic [OUT_W-1:0] outs_now();
        return {bus.grant_m1, bus.grant_m2, bus.bus_busy, bus.slave_select,
                bus.slave_en, bus.timeout};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_row(input int idx);
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] act;
        exp = exp_q.pop_front();
        act = outs_now();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row%0d {g1,g2,busy,ss,en,to}: got %b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
                     idx, act[9], act[8], act[7], act[6:5], act[4:1], act[0],
                     exp[9], exp[8], exp[7], exp[6:5], exp[4:1], exp[0]);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int hi;
        logic seen;

        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

        //   rst r1 r2 s1 s2 done | g1 g2 busy ss en       to
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 4'b0000, 0); // 0 reset state
        // both requesting: three transfers, one RELEASE between each
        add(0, 1, 1, 1, 3, 0,   1, 0, 1, 2'd1, 4'b0010, 0); // 1 m1 wins first tie
        add(0, 1, 1, 1, 3, 1,   0, 0, 0, 2'd1, 4'b0000, 0); // 2 done -> RELEASE
`ifdef BUS_ARB_FIXED_PRIO_EN
        add(0, 1, 1, 1, 3, 0,   1, 0, 1, 2'd1, 4'b0010, 0); // 3 fixed: m1 again
        add(0, 1, 1, 1, 3, 1,   0, 0, 0, 2'd1, 4'b0000, 0); // 4
`else
        add(0, 1, 1, 1, 3, 0,   0, 1, 1, 2'd3, 4'b1000, 0); // 3 round-robin: m2
        add(0, 1, 1, 1, 3, 1,   0, 0, 0, 2'd3, 4'b0000, 0); // 4
`endif
        add(0, 1, 1, 1, 3, 0,   1, 0, 1, 2'd1, 4'b0010, 0); // 5 m1
        add(0, 1, 1, 1, 3, 1,   0, 0, 0, 2'd1, 4'b0000, 0); // 6
        add(0, 0, 0, 1, 3, 0,   0, 0, 0, 2'd1, 4'b0000, 0); // 7 idle, ss held
        // single m1 transfer, select change during grant ignored
        add(0, 1, 0, 2, 0, 0,   1, 0, 1, 2'd2, 4'b0100, 0); // 8
        add(0, 1, 0, 3, 0, 0,   1, 0, 1, 2'd2, 4'b0100, 0); // 9
        add(0, 1, 0, 3, 0, 1,   0, 0, 0, 2'd2, 4'b0000, 0); // 10 done
        add(0, 0, 0, 3, 0, 1,   0, 0, 0, 2'd2, 4'b0000, 0); // 11 stray done ignored
        // m2 held with no done: 4 granted cycles then timeout
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 12
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 13
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 14
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 15
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 2'd0, 4'b0000, 1); // 16 timeout
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 17 regrant
        // done on the 4th granted cycle beats the timeout
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 18
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 19
        add(0, 0, 1, 0, 0, 0,   0, 1, 1, 2'd0, 4'b0001, 0); // 20
        add(0, 0, 1, 0, 0, 1,   0, 0, 0, 2'd0, 4'b0000, 0); // 21 no timeout
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 2'd0, 4'b0000, 0); // 22
        // m1 abandons, pending m2 granted after RELEASE
        add(0, 1, 0, 1, 2, 0,   1, 0, 1, 2'd1, 4'b0010, 0); // 23
        add(0, 0, 1, 1, 2, 0,   0, 0, 0, 2'd1, 4'b0000, 0); // 24 abandon
        add(0, 0, 1, 1, 2, 0,   0, 1, 1, 2'd2, 4'b0100, 0); // 25 m2
        // reset mid-transfer, then both request -> m1 first
        add(1, 0, 1, 1, 2, 0,   0, 0, 0, 2'd0, 4'b0000, 0); // 26
        add(0, 1, 1, 3, 1, 0,   1, 0, 1, 2'd3, 4'b1000, 0); // 27
        add(0, 1, 0, 3, 1, 1,   0, 0, 0, 2'd3, 4'b0000, 0); // 28
        add(0, 0, 0, 3, 1, 0,   0, 0, 0, 2'd3, 4'b0000, 0); // 29

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].r1, vecs[i].r2, vecs[i].s1, vecs[i].s2, vecs[i].done);
            exp_q.push_back({vecs[i].g1, vecs[i].g2, vecs[i].busy, vecs[i].ss,
                             vecs[i].en, vecs[i].to});
            @(posedge clk);
            #1;
            check_row(i);
            check_bit("mutex", bus.grant_m1 & bus.grant_m2, 1'b0);
        end

        // Hand sequence: m1 held alone -> grant high exactly 4 cycles,
        // timeout pulse with grant low, then same-master regrant.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = bus.grant_m1;
        end
        check_bit("seq_grant_seen", seen, 1'b1);
        hi = 1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.grant_m1) hi++;
            else break;
        end
        check_int("seq_hold_cycles", hi, 4);
        check_bit("seq_timeout_pulse", bus.timeout, 1'b1);
        check_bit("seq_busy_release", bus.bus_busy, 1'b0);
        @(posedge clk);
        #1;
        check_bit("seq_regrant_m1", bus.grant_m1, 1'b1);
        check_bit("seq_timeout_clear", bus.timeout, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check_bit("seq_drop_grant", bus.grant_m1, 1'b0);
        check_bit("seq_drop_no_timeout", bus.timeout, 1'b0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
